mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter word, 32, data/address width.
REQ-002 Parameter STARVE_LIMIT, 4, consecutive MEM grants allowed while IF waits.
REQ-003 Clock  input  1  single clock, all state updates on posedge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 IF_Req  input  1  instruction-fetch read request, held until IF_Ack.
REQ-006 IF_Addr  input  word  fetch address.
REQ-007 IF_Ack  output  1  one-cycle fetch completion pulse.
REQ-008 IF_Rdata  output  word  fetched instruction, valid with IF_Ack and held after.
REQ-009 MEM_MemRead  input  1  MEM-stage load request.
REQ-010 MEM_MemWrite  input  1  MEM-stage store request.
REQ-011 MEM_Addr  input  word  load/store address (MEM-stage ALU result).
REQ-012 MEM_Wdata  input  word  store data.
REQ-013 MEM_Ack  output  1  one-cycle load/store completion pulse.
REQ-014 MEM_Rdata  output  word  load data, valid with MEM_Ack and held after.
REQ-015 Stall  output  1  freeze pipeline registers.
REQ-016 Mem_Req, Mem_We  output  1 each  memory request, write enable.
REQ-017 Mem_Addr, Mem_Wdata  output  word each  memory address, write data.
REQ-018 Mem_Ready  input  1  memory completion, any latency >= 1 cycle.
REQ-019 Mem_Rdata  input  word  memory read data, valid with Mem_Ready.

Function
REQ-020 FSM states: IDLE, GRANT_IF, GRANT_MEM, DONE.
REQ-021 IDLE: MEM pending (MemRead|MemWrite) and starve count < STARVE_LIMIT -> GRANT_MEM; else IF_Req -> GRANT_IF; else MEM pending -> GRANT_MEM; else stay.
REQ-022 On grant edge, the winning address, write data and we are latched; Mem_Req, Mem_We, Mem_Addr, Mem_Wdata are driven from latched registers only.
REQ-023 Mem_Req = 1 throughout GRANT_IF/GRANT_MEM, 0 in IDLE/DONE.
REQ-024 GRANT_x with Mem_Ready = 1 -> DONE; matching Ack = 1 during DONE only; read data registered from Mem_Rdata on that edge.
REQ-025 DONE -> IDLE unconditionally; requests ignored in DONE (no re-grant of the just-acked request).
REQ-026 Minimum transaction: grant edge, 1 cycle Mem_Req, Ack next cycle; back-to-back grant spacing 3 cycles.
REQ-027 MemRead and MemWrite both high: treated as store, Mem_We = 1.
REQ-028 MEM_Rdata updates only on load completions; stores leave it unchanged; IF_Rdata updates only on fetch completions.
REQ-029 Starve counter: 3-bit, +1 on each MEM grant while IF_Req = 1, saturates at STARVE_LIMIT, cleared on each IF grant.
REQ-030 Stall = MEM pending and not MEM_Ack (combinational); Stall = 0 when no MEM request.
REQ-031 Inputs changing during GRANT_x have no effect on the in-flight transaction.
REQ-032 Mem_Ready outside GRANT_x ignored.

Reset
REQ-033 Reset_n low: state IDLE, Mem_Req/Mem_We/IF_Ack/MEM_Ack 0, Mem_Addr/Mem_Wdata/IF_Rdata/MEM_Rdata 0, starve counter 0, immediately (asynchronous).
REQ-034 Reset mid-transaction abandons it; no Ack is ever issued for it.
REQ-035 First grant possible on the first posedge after Reset_n rises.

Structure
REQ-036 Shared package pipeline_pkg holds word width, FSM state encoding, STARVE_LIMIT default.
REQ-037 Single module; no sub-module, starve counter inline.

Verification
REQ-038 IF_Req=1, IF_Addr=0x0040, memory latency 2 -> IF_Ack pulse 1 cycle, IF_Rdata = memory word, Stall = 0.
REQ-039 IF_Req and MEM_MemRead same cycle, MEM_Addr=0x1000 -> MEM granted first, Stall=1 until MEM_Ack, then IF granted.
REQ-040 MEM requests continuous with IF_Req held -> exactly 4 MEM grants, then IF grant, counter back to 0.
REQ-041 MEM_MemWrite=1, MEM_Wdata=0xDEADBEEF, addr 0x2000 -> Mem_We=1, memory holds 0xDEADBEEF, MEM_Rdata unchanged.
REQ-042 Reset_n low during GRANT_MEM with Mem_Ready pending -> Mem_Req=0 immediately, no MEM_Ack, IDLE after release.
REQ-043 MemRead and MemWrite both 1 -> store issued, Mem_We=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared widths, arbiter FSM encoding and starvation default
//               used by the pipeline memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam int WORD_W           = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_IF  = 2'd1,
    ST_GRANT_MEM = 2'd2,
    ST_DONE      = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates one single-ported memory between instruction fetch
//               and the MEM stage. MEM has priority, bounded by a starvation
//               counter so a waiting fetch is eventually served.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int WORD         = WORD_W,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            IF_Req,
  input  logic [WORD-1:0] IF_Addr,
  output logic            IF_Ack,
  output logic [WORD-1:0] IF_Rdata,
  input  logic            MEM_MemRead,
  input  logic            MEM_MemWrite,
  input  logic [WORD-1:0] MEM_Addr,
  input  logic [WORD-1:0] MEM_Wdata,
  output logic            MEM_Ack,
  output logic [WORD-1:0] MEM_Rdata,
  output logic            Stall,
  output logic            Mem_Req,
  output logic            Mem_We,
  output logic [WORD-1:0] Mem_Addr,
  output logic [WORD-1:0] Mem_Wdata,
  input  logic            Mem_Ready,
  input  logic [WORD-1:0] Mem_Rdata
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [WORD-1:0]     addr_q, addr_d;
  logic [WORD-1:0]     wdata_q, wdata_d;
  logic [WORD-1:0]     if_rdata_q, if_rdata_d;
  logic [WORD-1:0]     mem_rdata_q, mem_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                mem_ack_q, mem_ack_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic mem_pend;
  logic starve_ok;

  assign mem_pend  = MEM_MemRead | MEM_MemWrite;
  assign starve_ok = (starve_q < STARVE_MAX);

  // Next-state, grant latching and completion capture.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    starve_d    = starve_q;

    case (state_q)
      ST_IDLE: begin
        // MEM wins unless a waiting fetch has already been passed over
        // STARVE_LIMIT times; with no fetch waiting MEM always wins.
        if (mem_pend && (starve_ok || !IF_Req)) begin
          state_d = ST_GRANT_MEM;
          req_d   = 1'b1;
          we_d    = MEM_MemWrite;   // read+write together is a store
          addr_d  = MEM_Addr;
          wdata_d = MEM_Wdata;
          if (IF_Req && starve_ok) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end else if (IF_Req) begin
          state_d  = ST_GRANT_IF;
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = IF_Addr;
          starve_d = '0;
        end
      end
      ST_GRANT_IF: begin
        if (Mem_Ready) begin
          state_d    = ST_DONE;
          req_d      = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = Mem_Rdata;
        end
      end
      ST_GRANT_MEM: begin
        if (Mem_Ready) begin
          state_d   = ST_DONE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          mem_ack_d = 1'b1;
          if (!we_q) begin
            mem_rdata_d = Mem_Rdata;
          end
        end
      end
      default: begin
        // DONE: one ack cycle, requests deliberately ignored here.
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      starve_q    <= starve_d;
    end
  end

  assign Mem_Req   = req_q;
  assign Mem_We    = we_q;
  assign Mem_Addr  = addr_q;
  assign Mem_Wdata = wdata_q;
  assign IF_Ack    = if_ack_q;
  assign IF_Rdata  = if_rdata_q;
  assign MEM_Ack   = mem_ack_q;
  assign MEM_Rdata = mem_rdata_q;
  assign Stall     = mem_pend & ~mem_ack_q;

endmodule
`default_nettype wire
